booth_mult: RTL and testbench
=============================

BOOTH_MULT -- requirements
Module: booth_mult

Interface
REQ-001 SHALL have parameter: DATA_W, 32, operand width; HI and LO are each DATA_W bits wide.
REQ-002 SHALL have port: clock  in  1  rising-edge clock.
REQ-003 SHALL have port: reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port: A  in  DATA_W  multiplicand, two's complement.
REQ-005 SHALL have port: B  in  DATA_W  multiplier, two's complement.
REQ-006 SHALL have port: mult_start  in  1  start pulse; A and B are sampled on the same edge.
REQ-007 SHALL have port: mult_end  out  1  one-cycle pulse marking HI/LO valid.
REQ-008 SHALL have port: busy  out  1  high while in the LOAD or RUN state.
REQ-009 SHALL have port: HI  out  DATA_W  upper half of the signed product.
REQ-010 SHALL have port: LO  out  DATA_W  lower half of the signed product.

Function
REQ-011 SHALL implement a radix-2 Booth FSM with states IDLE, LOAD, RUN and DONE.
REQ-012 SHALL handle mult_start in any state as follows: latch M=A and Q=B, clear acc and q_m1, set count=DATA_W, go to LOAD; a start in LOAD/RUN/DONE aborts the current operation and restarts it.
REQ-013 SHALL run LOAD -> RUN unconditionally on the next edge.
REQ-014 SHALL perform one Booth step per RUN cycle on {q[0], q_m1}: 01 -> acc+=M, 10 -> acc-=M, 00/11 -> no change; then arithmetic right shift of {acc,Q,q_m1}; then count-=1.
REQ-015 SHALL hold acc at DATA_W+1 bits with M sign-extended, so that A = -2^(DATA_W-1) is handled without error.
REQ-016 SHALL, when the RUN step drives count to 0, register HI=acc[DATA_W-1:0] and LO=Q and move to DONE.
REQ-017 SHALL assert mult_end only in DONE, for exactly one cycle; DONE -> IDLE on the next edge unless mult_start is high.
REQ-018 SHALL present mult_end during the 34th cycle after the mult_start edge (1 LOAD + 32 RUN + 1 DONE, DATA_W=32).
REQ-019 SHALL hold HI/LO stable from DONE until the next DONE; a restart does not clear them.
REQ-020 SHALL produce a HI:LO equal to the exact 2*DATA_W-bit signed product A*B for all operand pairs.
REQ-021 SHALL ignore A/B changes after the sampling edge.

Reset
REQ-022 SHALL, on reset, set state=IDLE, HI=0, LO=0, mult_end=0, busy=0, acc=0, count=0 and mult_overflow=0; reset overrides a simultaneous mult_start.
REQ-023 SHALL abandon an operation when reset arrives mid-operation; no mult_end follows.

Configuration
REQ-024 SHALL, with MULT_OVERFLOW_EN defined, add output port mult_overflow (1 bit) set in DONE when HI != {DATA_W{LO[DATA_W-1]}} and held alongside HI/LO.
REQ-025 SHALL, without MULT_OVERFLOW_EN, have no mult_overflow port and no comparison logic.

Structure
REQ-026 SHALL place the state enum, DATA_W default and count width constant in shared package mult_pkg.
REQ-027 SHALL place the combinational add/subtract-and-shift in sub-module booth_step, instantiated once.

Verification
REQ-028 SHALL cover: A=3, B=4, start -> mult_end 34 cycles later, HI=0x00000000, LO=0x0000000C, busy low after.
REQ-029 SHALL cover: A=-7 (0xFFFFFFF9), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFDD.
REQ-030 SHALL cover: A=B=0x80000000 -> HI=0x40000000, LO=0x00000000, mult_overflow=1 when MULT_OVERFLOW_EN is defined.
REQ-031 SHALL cover: A=-1, B=-1 -> HI=0, LO=1, mult_overflow=0.
REQ-032 SHALL cover: start A=2, B=2, restart at RUN cycle 10 with A=6, B=7 -> a single mult_end 34 cycles after the restart, LO=42.
REQ-033 SHALL cover: reset at RUN cycle 15 -> no mult_end, HI=LO=0, state IDLE.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the Booth multiplier.
// Holds the FSM state enum, default operand width and count width.
package mult_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    // Counter must hold the value DATA_W itself.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_w(DATA_W_DEF);

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M, then
// arithmetic right shift of {acc, Q, q_m1}. Purely combinational.
import mult_pkg::*;

module booth_step #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W:0]   i_acc,
    input  logic [DATA_W-1:0] i_q,
    input  logic              i_qm1,
    input  logic [DATA_W:0]   i_m,
    output logic [DATA_W:0]   o_acc,
    output logic [DATA_W-1:0] o_q,
    output logic              o_qm1
);

    logic [DATA_W:0] w_sum;

    // Select add, subtract or pass-through from the Booth pair.
    always_comb begin
        w_sum = i_acc;
        case ({i_q[0], i_qm1})
            2'b01:   w_sum = i_acc + i_m;
            2'b10:   w_sum = i_acc - i_m;
            default: w_sum = i_acc;
        endcase
    end

    assign {o_acc, o_q, o_qm1} = {w_sum[DATA_W], w_sum, i_q};

endmodule

// File: rtl/booth_mult.sv
// Sequential radix-2 Booth signed multiplier (IDLE/LOAD/RUN/DONE).
// Define MULT_OVERFLOW_EN to add the mult_overflow output.
import mult_pkg::*;

module booth_mult #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              mult_start,
    output logic              mult_end,
    output logic              busy,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO
`ifdef MULT_OVERFLOW_EN
    ,
    output logic              mult_overflow
`endif
);

    localparam int CW = cnt_w(DATA_W);

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W:0]   r_m;
    logic [DATA_W:0]   r_acc;
    logic [DATA_W-1:0] r_q;
    logic              r_qm1;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W:0]   w_acc_n;
    logic [DATA_W-1:0] w_q_n;
    logic              w_qm1_n;
    logic              w_last;

    assign w_last = (r_state == S_RUN) && (r_count == CW'(1));

    booth_step #(.DATA_W(DATA_W)) u_step (
        .i_acc (r_acc),
        .i_q   (r_q),
        .i_qm1 (r_qm1),
        .i_m   (r_m),
        .o_acc (w_acc_n),
        .o_q   (w_q_n),
        .o_qm1 (w_qm1_n)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state and status outputs; a start always (re)enters LOAD.
    always_comb begin
        w_next   = r_state;
        mult_end = 1'b0;
        busy     = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_IDLE;
            S_LOAD: begin
                busy   = 1'b1;
                w_next = S_RUN;
            end
            S_RUN: begin
                busy   = 1'b1;
                w_next = w_last ? S_DONE : S_RUN;
            end
            S_DONE: begin
                mult_end = 1'b1;
                w_next   = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (mult_start) w_next = S_LOAD;
    end

    // Operand capture, Booth iteration and result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (mult_start) begin
            r_m     <= {A[DATA_W-1], A};
            r_acc   <= '0;
            r_q     <= B;
            r_qm1   <= 1'b0;
            r_count <= CW'(DATA_W);
        end else if (r_state == S_RUN) begin
            r_acc   <= w_acc_n;
            r_q     <= w_q_n;
            r_qm1   <= w_qm1_n;
            r_count <= r_count - CW'(1);
            if (w_last) begin
                r_hi <= w_acc_n[DATA_W-1:0];
                r_lo <= w_q_n;
            end
        end
    end

    assign HI = r_hi;
    assign LO = r_lo;

`ifdef MULT_OVERFLOW_EN
    logic r_ovf;

    // Flag a product that does not fit in DATA_W signed bits.
    always_ff @(posedge clock) begin
        if (reset)
            r_ovf <= 1'b0;
        else if (!mult_start && w_last)
            r_ovf <= (w_acc_n[DATA_W-1:0] != {DATA_W{w_q_n[DATA_W-1]}});
    end

    assign mult_overflow = r_ovf;
`endif

endmodule

// File: tb/tb_booth_mult.sv
// Randomised self-checking bench for booth_mult against a plain
// signed-multiply reference model.
module tb_booth_mult;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic        mult_start;
    logic        mult_end;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
`ifdef MULT_OVERFLOW_EN
    logic        mult_overflow;
`endif

    int total = 0;
    int bad   = 0;
    logic [63:0] prev_prod = '0;

    booth_mult #(.DATA_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .A          (A),
        .B          (B),
        .mult_start (mult_start),
        .mult_end   (mult_end),
        .busy       (busy),
        .HI         (HI),
        .LO         (LO)
`ifdef MULT_OVERFLOW_EN
        ,
        .mult_overflow (mult_overflow)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    function automatic logic ref_ovf(input logic [63:0] p);
        longint sp;
        sp = longint'(p);
        return (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
    endfunction

    // Pulse start at a negedge; sampling happens on the next posedge.
    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        A = a;
        B = b;
        mult_start = 1'b1;
        @(posedge clock);
        #1;
        mult_start = 1'b0;
        A = $urandom;
        B = $urandom;
    endtask

    // Wait for mult_end after a start; cyc is the cycle index (1 = LOAD).
    task automatic wait_end(input string tag, input logic [63:0] exp);
        int cyc;
        cyc = 1;
        chk({tag, "_busy_load"}, 64'(busy), 64'd1);
        while (!mult_end && cyc < 60) begin
            @(posedge clock);
            #1;
            cyc++;
            if (cyc == 2)
                chk({tag, "_hold"}, {HI, LO}, prev_prod);
        end
        chk({tag, "_lat"}, 64'(cyc), 64'd34);
        chk({tag, "_prod"}, {HI, LO}, exp);
`ifdef MULT_OVERFLOW_EN
        chk({tag, "_ovf"}, 64'(mult_overflow), 64'(ref_ovf(exp)));
`endif
        prev_prod = exp;
        @(posedge clock);
        #1;
        chk({tag, "_end1"}, 64'(mult_end), 64'd0);
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        chk({tag, "_keep"}, {HI, LO}, exp);
    endtask

    task automatic do_mult(input string tag, input logic [31:0] a,
                           input logic [31:0] b);
        logic [63:0] exp;
        exp = ref_prod(a, b);
        pulse_start(a, b);
        wait_end(tag, exp);
    endtask

    initial begin
        int ends;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1;
        mult_start = 1'b1;
        A = 32'd5;
        B = 32'd5;
        repeat (3) @(posedge clock);
        #1;
        mult_start = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_hilo", {HI, LO}, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_end", 64'(mult_end), 64'd0);
        @(posedge clock);
        #1;
        chk("rst_idle", 64'(busy), 64'd0);

        do_mult("m3x4", 32'd3, 32'd4);
        chk("m3x4_exact", {HI, LO}, 64'h0000_0000_0000_000C);
        do_mult("mneg7x5", 32'hFFFF_FFF9, 32'd5);
        chk("mneg7x5_exact", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFDD);
        do_mult("mmin", 32'h8000_0000, 32'h8000_0000);
        chk("mmin_exact", {HI, LO}, 64'h4000_0000_0000_0000);
        do_mult("mm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("mm1_exact", {HI, LO}, 64'h0000_0000_0000_0001);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) ra = 32'h8000_0000;
            if (i == 1) rb = 32'h8000_0000;
            if (i == 2) rb = 32'h7FFF_FFFF;
            if (i == 3) ra = 32'd0;
            do_mult($sformatf("rnd%0d", i), ra, rb);
        end

        // Restart mid-run: only the second operation may complete.
        pulse_start(32'd2, 32'd2);
        ends = 0;
        repeat (10) begin
            @(posedge clock);
            #1;
            if (mult_end) ends++;
        end
        chk("rs_noend", 64'(ends), 64'd0);
        do_mult("rs", 32'd6, 32'd7);
        chk("rs_lo42", 64'(LO), 64'd42);
        ends = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (mult_end) ends++;
        end
        chk("rs_single", 64'(ends), 64'd0);

        // Reset mid-run: abandoned, no completion pulse.
        pulse_start(32'd9, 32'd9);
        repeat (15) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rr_hilo", {HI, LO}, 64'd0);
        ends = 0;
        repeat (50) begin
            @(posedge clock);
            #1;
            if (mult_end) ends++;
        end
        chk("rr_noend", 64'(ends), 64'd0);
        chk("rr_busy", 64'(busy), 64'd0);
        chk("rr_hilo2", {HI, LO}, 64'd0);
`ifdef MULT_OVERFLOW_EN
        chk("rr_ovf", 64'(mult_overflow), 64'd0);
`endif
        prev_prod = '0;
        do_mult("post_rst", 32'hFFFF_FFFE, 32'd100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
